// File: rtl/multi_decode_stage.sv
// N-wide RV32IM decode stage: per-lane combinational decode, registered output
// bundle behind a valid/ready handshake with a one-bundle skid register.
module multi_decode_stage #(
  parameter int DECODE_WIDTH = 2,
  parameter int ID_WIDTH     = 4,
  localparam int INFO_W      = 179
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           fetch_valid,
  output logic                           decode_ready,
  input  logic [DECODE_WIDTH-1:0]        fetch_lane_valid,
  input  logic [DECODE_WIDTH*32-1:0]     fetch_pc,
  input  logic [DECODE_WIDTH*32-1:0]     imem_rdata,
  output logic                           decode_valid,
  input  logic                           iq_ready,
  output logic [DECODE_WIDTH*INFO_W-1:0] instruction_info,
  output logic [DECODE_WIDTH-1:0]        lane_valid_out,
  output logic [DECODE_WIDTH-1:0]        illegal,
  output logic [ID_WIDTH-1:0]            group_id
);

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc_curr;
    logic [31:0] pc_next;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] immediate;
    logic [1:0]  operand1;
    logic [1:0]  operand2;
    logic        alu_en;
    logic [3:0]  alu_operation;
    logic        cmp_en;
    logic [2:0]  cmp_operation;
    logic        is_branch;
    logic        is_jump;
    logic        is_mul;
    logic [1:0]  mul_type;
  } info_t;

  localparam logic [6:0] OP_B_REG   = 7'b0110011;
  localparam logic [6:0] OP_B_IMM   = 7'b0010011;
  localparam logic [6:0] OP_B_LUI   = 7'b0110111;
  localparam logic [6:0] OP_B_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_B_BR    = 7'b1100011;
  localparam logic [6:0] OP_B_JAL   = 7'b1101111;
  localparam logic [6:0] OP_B_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_B_STORE = 7'b0100011;

  // ALU codes reuse funct3 in the low bits; bit 3 selects the alternate (sub/sra)
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b1101;
  localparam logic [2:0] CMP_BLT  = 3'b100;
  localparam logic [2:0] CMP_BLTU = 3'b110;

  function automatic info_t decode_lane(input logic [31:0] w, input logic [31:0] pc,
                                        input logic v);
    info_t d;
    logic signed [31:0] i_imm, s_imm, b_imm, j_imm;
    logic        [31:0] u_imm;
    i_imm = {{20{w[31]}}, w[31:20]};
    s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
    b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    u_imm = {w[31:12], 12'h000};
    d               = '0;
    d.valid         = v;
    d.inst          = w;
    d.pc_curr       = pc;
    d.pc_next       = pc + 32'd4;
    d.opcode        = w[6:0];
    d.funct3        = w[14:12];
    d.funct7        = w[31:25];
    d.rs1_s         = w[19:15];
    d.rs2_s         = w[24:20];
    d.rd_s          = w[11:7];
    d.alu_en        = 1'b1;
    d.cmp_en        = 1'b1;
    d.alu_operation = ALU_ADD;
    d.cmp_operation = w[14:12];
    d.immediate     = u_imm;
    case (w[6:0])
      OP_B_REG, OP_B_IMM: begin
        if (w[6:0] == OP_B_REG && w[31:25] == 7'b0000001) begin
          d.is_mul = 1'b1;
          d.alu_en = 1'b0;
          d.cmp_en = 1'b0;
          case (w[14:12])
            3'b000, 3'b001: d.mul_type = 2'b01;
            3'b010:         d.mul_type = 2'b10;
            default:        d.mul_type = 2'b00;
          endcase
        end else begin
          case (w[14:12])
            3'b010: begin d.cmp_operation = CMP_BLT;  d.alu_en = 1'b0; end
            3'b011: begin d.cmp_operation = CMP_BLTU; d.alu_en = 1'b0; end
            3'b101: d.alu_operation = w[30] ? ALU_SRA : ALU_SRL;
            // addi has no subtract form: bit 30 is part of its immediate
            3'b000: d.alu_operation = (w[6:0] == OP_B_REG && w[30]) ? ALU_SUB : ALU_ADD;
            default: d.alu_operation = {1'b0, w[14:12]};
          endcase
          if (w[6:0] == OP_B_IMM) begin
            d.operand2  = 2'b11;
            d.immediate = i_imm;
            d.rs2_s     = 5'd0;
          end
        end
      end
      OP_B_LUI: begin
        d.operand1 = 2'b10;
        d.operand2 = 2'b01;
        d.rs1_s    = 5'd0;
        d.rs2_s    = 5'd0;
      end
      OP_B_AUIPC: begin
        d.operand1 = 2'b01;
        d.operand2 = 2'b01;
      end
      OP_B_BR: begin
        d.immediate = b_imm;
        d.is_branch = 1'b1;
      end
      OP_B_JAL, OP_B_JALR: begin
        d.operand1  = 2'b11;
        d.operand2  = 2'b11;
        d.immediate = (w[6:0] == OP_B_JAL) ? j_imm : i_imm;
        d.is_jump   = 1'b1;
        d.cmp_en    = 1'b0;
      end
      OP_B_LOAD: begin
        d.operand2  = 2'b11;
        d.immediate = i_imm;
        d.cmp_en    = 1'b0;
      end
      OP_B_STORE: begin
        d.operand2  = 2'b11;
        d.immediate = s_imm;
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic lane_illegal(input logic [31:0] w, input logic v);
    logic bad;
    case (w[6:0])
      OP_B_REG:  bad = (w[31:25] == 7'b0000001) && w[14];
      OP_B_IMM, OP_B_LUI, OP_B_AUIPC, OP_B_BR, OP_B_JAL, OP_B_JALR,
      OP_B_LOAD, OP_B_STORE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad & v;
  endfunction

  logic [DECODE_WIDTH*INFO_W-1:0] dec_info_p0;
  logic [DECODE_WIDTH-1:0]        dec_illegal_p0;

  always_comb begin
    dec_info_p0    = '0;
    dec_illegal_p0 = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      dec_info_p0[i*INFO_W +: INFO_W] = decode_lane(imem_rdata[i*32 +: 32],
                                                    fetch_pc[i*32 +: 32],
                                                    fetch_lane_valid[i]);
      dec_illegal_p0[i] = lane_illegal(imem_rdata[i*32 +: 32], fetch_lane_valid[i]);
    end
  end

  // ---- p0 -> p1: OUT and SKID bundle registers ----
  logic [DECODE_WIDTH*INFO_W-1:0] out_info_p1, skid_info_p1;
  logic [DECODE_WIDTH-1:0]        out_lanes_p1, skid_lanes_p1;
  logic [DECODE_WIDTH-1:0]        out_illegal_p1, skid_illegal_p1;
  logic [ID_WIDTH-1:0]            out_gid_p1, skid_gid_p1;
  logic                           vld_p1, skid_vld_p1, rdy_p1;
  logic [ID_WIDTH-1:0]            gid_q;

  logic accept, transfer, load_out_new, load_out_skid, load_skid_new;
  logic vld_nxt, skid_vld_nxt;

  always_comb begin
    accept        = fetch_valid & rdy_p1 & ~flush;
    transfer      = vld_p1 & iq_ready;
    load_out_new  = accept & (~vld_p1 | (transfer & ~skid_vld_p1));
    load_out_skid = transfer & skid_vld_p1 & ~flush;
    load_skid_new = accept & vld_p1 & (~transfer | skid_vld_p1);
    vld_nxt       = vld_p1;
    skid_vld_nxt  = skid_vld_p1;
    if (load_out_new | load_out_skid) vld_nxt = 1'b1;
    else if (transfer)                vld_nxt = 1'b0;
    if (load_skid_new)                skid_vld_nxt = 1'b1;
    else if (load_out_skid)           skid_vld_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b1;
      gid_q       <= '0;
    end else begin
      if (accept) gid_q <= gid_q + 1'b1;
      if (flush) begin
        vld_p1      <= 1'b0;
        skid_vld_p1 <= 1'b0;
        rdy_p1      <= 1'b1;
      end else begin
        vld_p1      <= vld_nxt;
        skid_vld_p1 <= skid_vld_nxt;
        rdy_p1      <= ~skid_vld_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_out_new) begin
      out_info_p1    <= dec_info_p0;
      out_lanes_p1   <= fetch_lane_valid;
      out_illegal_p1 <= dec_illegal_p0;
      out_gid_p1     <= gid_q;
    end else if (load_out_skid) begin
      out_info_p1    <= skid_info_p1;
      out_lanes_p1   <= skid_lanes_p1;
      out_illegal_p1 <= skid_illegal_p1;
      out_gid_p1     <= skid_gid_p1;
    end
    if (load_skid_new) begin
      skid_info_p1    <= dec_info_p0;
      skid_lanes_p1   <= fetch_lane_valid;
      skid_illegal_p1 <= dec_illegal_p0;
      skid_gid_p1     <= gid_q;
    end
  end

  // Data registers carry no reset; an empty OUT presents an all-zero bundle
  assign decode_valid     = vld_p1;
  assign decode_ready     = rdy_p1;
  assign instruction_info = vld_p1 ? out_info_p1 : '0;
  assign lane_valid_out   = vld_p1 ? out_lanes_p1 : '0;
  assign illegal          = vld_p1 ? out_illegal_p1 : '0;
  assign group_id         = vld_p1 ? out_gid_p1 : '0;

endmodule

// File: doc/multi_decode_stage.md
# multi_decode_stage

N-wide registered decode stage between fetch and the instruction queue, the next generation of our single-lane combinational decoder. Decodes up to DECODE_WIDTH RV32IM instruction words per cycle into `instruction_info_reg_t` records, registers them behind a valid/ready handshake with a two-entry skid buffer, tags each bundle with a wrapping group ID, and supports a same-cycle pipeline flush. Adds full M-extension decode, illegal-opcode detection and corrected JALR/LUI handling.

## Interface
- DECODE_WIDTH, 2, lanes per bundle (1..4)
- ID_WIDTH, 4, group ID counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all held and incoming bundles this cycle
- fetch_valid  in  1  upstream bundle present
- decode_ready  out  1  block can accept a bundle (registered)
- fetch_lane_valid  in  DECODE_WIDTH  per-lane occupancy of incoming bundle
- fetch_pc  in  DECODE_WIDTH×32  per-lane PC
- imem_rdata  in  DECODE_WIDTH×32  per-lane instruction word
- decode_valid  out  1  output bundle present
- iq_ready  in  1  instruction queue accepts output bundle
- instruction_info  out  DECODE_WIDTH×instruction_info_reg_t  decoded lanes
- lane_valid_out  out  DECODE_WIDTH  per-lane occupancy of output bundle
- illegal  out  DECODE_WIDTH  lane holds an unsupported encoding
- group_id  out  ID_WIDTH  bundle sequence tag

## Operation
- Accept = fetch_valid & decode_ready & !flush. Transfer = decode_valid & iq_ready.
- Per lane, combinational decode of imem_rdata: funct3/funct7/opcode/rs1_s/rs2_s/rd_s/inst copied; pc_curr = fetch_pc; pc_next = fetch_pc + 4 (mod 2^32); info.valid = fetch_lane_valid.
- Defaults: alu_en=1, cmp_en=1, alu_operation=alu_add, cmp_operation=funct3, is_branch=is_jump=is_mul=0, mul_type=2'b00, operands 2'b00, immediate=u_imm.
- op_b_reg, funct7=7'b0000001: is_mul=1, alu_en=cmp_en=0; funct3 000/001→mul_type 01, 010→10, 011→00; funct3 1xx (div/rem) → illegal=1.
- op_b_reg otherwise: slt→cmp blt, alu_en=0; sltu→bltu, alu_en=0; sr→alu_sra if funct7[5] else alu_srl; add→alu_sub if funct7[5] else alu_add; others alu_operation=funct3.
- op_b_imm: as op_b_reg non-M minus sub; operand2=2'b11, immediate=i_imm, rs2_s=0.
- op_b_lui: operand1=2'b10, operand2=2'b01, immediate=u_imm, rs1_s=rs2_s=0. op_b_auipc: operands 01/01, u_imm.
- op_b_br: b_imm, is_branch=1. op_b_jal: operands 11/11, j_imm, is_jump=1, cmp_en=0. op_b_jalr: same but immediate=i_imm.
- op_b_load: operand2=11, i_imm, cmp_en=0. op_b_store: operand2=11, s_imm.
- Any other opcode: illegal=1 (only when lane valid). Invalid lanes: illegal=0.
- Storage: output register (OUT) + skid register (SKID), each holding full bundle + group_id.
  - Accept & (OUT empty | Transfer & !SKID valid) → OUT ← new.
  - Accept & OUT full & !Transfer → SKID ← new.
  - Transfer & SKID valid → OUT ← SKID, SKID empties; a simultaneous accept loads SKID.
- decode_ready ← !(SKID valid after this edge); decode_valid = OUT valid.
- group_id counter increments by 1 on each accept, wraps 2^ID_WIDTH−1→0; flush does not reset it.
- flush: OUT and SKID invalidated at next edge; incoming bundle discarded; counter unchanged.

## Timing
- Reset: decode_valid=0, decode_ready=1, lane_valid_out=0, illegal=0, group_id=0, instruction_info=0, SKID empty.
- Latency: accept at edge k → decode_valid high after edge k.
- Throughput: one bundle/cycle with iq_ready held high; SKID never used.
- iq_ready low with OUT full: one further bundle absorbed into SKID, decode_ready low from next cycle until SKID drains.
- Outputs stable while decode_valid & !iq_ready.
- Reset mid-operation clears all state immediately, independent of clk.

## Test plan
- Reset then single bundle {pc 0x1000 `add x1,x2,x3`, pc 0x1004 `mul x4,x5,x6`} → next cycle decode_valid=1, lane0 alu_add, lane1 is_mul=1 mul_type=01, pc_next 0x1004/0x1008, group_id=0.
- Stall: iq_ready=0, three back-to-back bundles → first two held (OUT, SKID), decode_ready=0 after second, third waits; release → in-order delivery, group_id 0,1,2.
- Flush with OUT and SKID full plus fetch_valid=1 → next cycle decode_valid=0, decode_ready=1, counter unchanged.
- Decode sweep: `jalr x1,8(x2)` → immediate 8, is_jump=1; `lui x3,0xABCDE` → immediate 0xABCDE000, operand1=10; `div` and opcode 7'b1111111 → illegal=1.
- Wrap: 17 accepts with ID_WIDTH=4 → group_id sequence 0..15,0.
- Lane mask 2'b01 with garbage in lane1 → lane_valid_out=01, lane1 illegal=0, info.valid=0.
